// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, assembles one- or two-word instructions
// (opcode plus optional immediate) and presents a registered packet to IF/ID.
//
// state | meaning
// ------+------------------------------------------------
// S_OP  | waiting for an opcode word at PC
// S_IMM | opcode held in held_op; waiting for its immediate word
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 16,
    parameter int                IMM_BIT  = 15,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk1,
    input  logic               fetchReset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [INSTR_W-1:0] if_imm,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_next
);

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   op_pc;
    logic [INSTR_W-1:0]  held_op;

    // Wraps modulo 2^ADDR_W, so the all-ones address rolls over to 0.
    assign pc_inc    = pc + ADDR_W'(1);
    assign imem_addr = pc;

    always_ff @(posedge clk1 or posedge fetchReset) begin
        if (fetchReset) begin
            pc         <= RESET_PC;
            state      <= S_OP;
            held_op    <= '0;
            op_pc      <= '0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_imm     <= '0;
            if_pc      <= '0;
            if_pc_next <= '0;
        end else if (branch_taken) begin
            // Redirect squashes any half-assembled instruction, even under stall.
            pc       <= branch_target;
            state    <= S_OP;
            held_op  <= '0;
            if_valid <= 1'b0;
        end else if (!stall) begin
            pc <= pc_inc;
            case (state)
                S_OP: begin
                    if (imem_data[IMM_BIT]) begin
                        held_op  <= imem_data;
                        op_pc    <= pc;
                        if_valid <= 1'b0;
                        state    <= S_IMM;
                    end else begin
                        if_valid   <= 1'b1;
                        if_instr   <= imem_data;
                        if_imm     <= '0;
                        if_pc      <= pc;
                        if_pc_next <= pc_inc;
                        state      <= S_OP;
                    end
                end
                S_IMM: begin
                    if_valid   <= 1'b1;
                    if_instr   <= held_op;
                    if_imm     <= imem_data;
                    if_pc      <= op_pc;
                    if_pc_next <= pc_inc;
                    state      <= S_OP;
                end
                default: begin
                    state    <= S_OP;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed literal checks plus a randomized
// stream compared every cycle against an instruction-level model of the fetch.
module tb_fetch_stage;

    logic        clk1 = 1'b0;
    logic        fetchReset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_imm;
    logic [31:0] if_pc;
    logic [31:0] if_pc_next;

    // Narrow instance exercising address wrap-around.
    logic [3:0]  s_addr;
    logic        s_valid;
    logic [15:0] s_instr;
    logic [15:0] s_imm;
    logic [3:0]  s_pc;
    logic [3:0]  s_pc_next;
    logic [3:0]  s_target;
    logic [15:0] s_data;
    logic        s_zero;

    logic [15:0] mem [256];

    int vectors = 0;
    int miscompares = 0;

    // Model: address of the current instruction start and words consumed of it.
    logic [31:0] m_s;
    int          m_k;
    logic        m_valid;
    logic [15:0] m_instr;
    logic [15:0] m_imm;
    logic [31:0] m_pc;
    logic [31:0] m_nx;

    always #5 clk1 = ~clk1;

    assign imem_data = mem[imem_addr[7:0]];
    assign s_target  = 4'h0;
    assign s_data    = 16'h0005;
    assign s_zero    = 1'b0;

    fetch_stage dut (
        .clk1(clk1), .fetchReset(fetchReset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .if_valid(if_valid), .if_instr(if_instr), .if_imm(if_imm),
        .if_pc(if_pc), .if_pc_next(if_pc_next)
    );

    fetch_stage #(.ADDR_W(4), .RESET_PC(4'hF)) dut_small (
        .clk1(clk1), .fetchReset(fetchReset), .stall(s_zero),
        .branch_taken(s_zero), .branch_target(s_target),
        .imem_addr(s_addr), .imem_data(s_data),
        .if_valid(s_valid), .if_instr(s_instr), .if_imm(s_imm),
        .if_pc(s_pc), .if_pc_next(s_pc_next)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rd(input logic [31:0] a);
        return mem[a[7:0]];
    endfunction

    task automatic model_step(input logic rst, input logic br, input logic st,
                              input logic [31:0] tgt);
        logic [15:0] op;
        if (rst) begin
            m_s = 32'h0; m_k = 0; m_valid = 1'b0;
            m_instr = '0; m_imm = '0; m_pc = '0; m_nx = '0;
        end else if (br) begin
            m_s = tgt; m_k = 0; m_valid = 1'b0;
        end else if (!st) begin
            op = rd(m_s);
            if (m_k == 0 && op[15]) begin
                m_k = 1;
                m_valid = 1'b0;
            end else if (m_k == 0) begin
                m_valid = 1'b1; m_instr = op; m_imm = '0;
                m_pc = m_s; m_nx = m_s + 32'd1; m_s = m_s + 32'd1;
            end else begin
                m_valid = 1'b1; m_instr = op; m_imm = rd(m_s + 32'd1);
                m_pc = m_s; m_nx = m_s + 32'd2; m_s = m_s + 32'd2; m_k = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("imem_addr", imem_addr, m_s + 32'(m_k));
        chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
        if (m_valid) begin
            chk("if_instr", {16'b0, if_instr}, {16'b0, m_instr});
            chk("if_imm", {16'b0, if_imm}, {16'b0, m_imm});
            chk("if_pc", if_pc, m_pc);
            chk("if_pc_next", if_pc_next, m_nx);
        end
    endtask

    // Apply one clock of inputs (driven while clk1 is low) and check the result.
    task automatic cycle(input logic br, input logic st, input logic [31:0] tgt);
        branch_taken  = br;
        stall         = st;
        branch_target = tgt;
        model_step(1'b0, br, st, tgt);
        @(negedge clk1);
        compare_all();
    endtask

    task automatic async_reset();
        fetchReset = 1'b1;
        model_step(1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        chk("rst_addr_immediate", imem_addr, 32'h0);
        chk("rst_valid_immediate", {31'b0, if_valid}, 32'h0);
        @(negedge clk1);
        compare_all();
        fetchReset = 1'b0;
    endtask

    initial begin
        int r;
        logic [31:0] tgt;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1234; mem[1] = 16'h8001; mem[2] = 16'hBEEF;
        mem[3] = 16'h0003; mem[4] = 16'h0004; mem[5] = 16'h0005;
        mem[6] = 16'h8ABC; mem[7] = 16'h7777;
        mem[8'h40] = 16'h0042; mem[8'h41] = 16'h0043;

        fetchReset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        model_step(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk1);
        compare_all();
        chk("reset_instr", {16'b0, if_instr}, 32'h0);
        chk("reset_imm", {16'b0, if_imm}, 32'h0);
        chk("reset_pc", if_pc, 32'h0);
        chk("reset_pc_next", if_pc_next, 32'h0);
        chk("small_reset_addr", {28'b0, s_addr}, 32'hF);
        fetchReset = 1'b0;

        cycle(1'b0, 1'b0, 32'h0);
        chk("one_word_instr", {16'b0, if_instr}, 32'h1234);
        chk("one_word_pc_next", if_pc_next, 32'h1);
        chk("small_pc", {28'b0, s_pc}, 32'hF);
        chk("small_pc_next_wrap", {28'b0, s_pc_next}, 32'h0);
        chk("small_addr_wrap", {28'b0, s_addr}, 32'h0);
        chk("small_valid", {31'b0, s_valid}, 32'h1);

        cycle(1'b0, 1'b0, 32'h0);
        chk("bubble_valid", {31'b0, if_valid}, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("two_word_instr", {16'b0, if_instr}, 32'h8001);
        chk("two_word_imm", {16'b0, if_imm}, 32'hBEEF);
        chk("two_word_pc", if_pc, 32'h1);
        chk("two_word_pc_next", if_pc_next, 32'h3);
        chk("two_word_addr", imem_addr, 32'h3);

        repeat (4) cycle(1'b0, 1'b0, 32'h0);
        chk("in_imm_addr", imem_addr, 32'h7);
        async_reset();
        cycle(1'b0, 1'b0, 32'h0);
        chk("after_rst_instr", {16'b0, if_instr}, 32'h1234);
        chk("after_rst_pc", if_pc, 32'h0);

        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h40);
        chk("branch_valid", {31'b0, if_valid}, 32'h0);
        chk("branch_addr", imem_addr, 32'h40);
        cycle(1'b0, 1'b0, 32'h0);
        chk("branch_pkt_pc", if_pc, 32'h40);
        chk("branch_pkt_instr", {16'b0, if_instr}, 32'h0042);

        repeat (3) begin
            cycle(1'b0, 1'b1, 32'h0);
            chk("stall_addr", imem_addr, 32'h41);
            chk("stall_pc", if_pc, 32'h40);
        end
        cycle(1'b0, 1'b0, 32'h0);
        chk("resume_pc", if_pc, 32'h41);

        cycle(1'b1, 1'b1, 32'h10);
        chk("branch_over_stall", imem_addr, 32'h10);

        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 1) begin
                async_reset();
            end else if (r < 9) begin
                tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE - 32'($urandom_range(0, 1))
                                                   : 32'($urandom_range(0, 255));
                cycle(1'b1, $urandom_range(0, 1) == 1, tgt);
            end else begin
                cycle(1'b0, $urandom_range(0, 3) == 0, 32'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
